// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scan/debounce/decode (clk, reset, row -> col_drive, key_value, key_valid, key_held); define KEYPAD_REPEAT_EN for auto-repeat
module keypad_scanner #(
  parameter int BASE = 10,
  parameter int SCAN_CYCLES = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col_drive,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);
  localparam int MAX_SD = SCAN_CYCLES > DEBOUNCE_CYCLES ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAXC = MAX_SD > REPEAT_CYCLES ? MAX_SD : REPEAT_CYCLES;
  localparam int W = $clog2(MAXC + 1);
  localparam logic [W-1:0] SC_LAST = W'(SCAN_CYCLES - 1);
  localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [W-1:0] RP_LAST = W'(REPEAT_CYCLES - 1);
`endif
  localparam logic [63:0] DEC10 = 64'hDE0F_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t state_q, state_d;
  logic [1:0] col_q, col_d, ridx;
  logic [W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0] row_q, row_d, key_value_q, key_value_d, dec;
  logic key_valid_q, key_valid_d, key_held_q, key_held_d, one_hot;
  always_comb begin
    one_hot = (row != 4'd0) && ((row & (row - 4'd1)) == 4'd0);
    ridx = {row_q[3] | row_q[2], row_q[3] | row_q[1]};
    dec = BASE == 10 ? DEC10[{ridx, col_q, 2'b00} +: 4] : {ridx, col_q};
    cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    state_d = state_q;
    col_d = col_q;
    cnt_d = cnt_inc;
    row_d = row_q;
    key_value_d = key_value_q;
    key_valid_d = 1'b0;
    key_held_d = key_held_q;
    case (state_q)
      SCAN:
        if (one_hot) begin
          state_d = DEBOUNCE;
          row_d = row;
          cnt_d = '0;
        end else if (cnt_q == SC_LAST) begin
          col_d = col_q + 2'd1;
          cnt_d = '0;
        end
      DEBOUNCE:
        if (row != row_q) begin
          state_d = SCAN;
          col_d = col_q + 2'd1;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d = '0;
          key_value_d = dec;
          key_valid_d = 1'b1;
          key_held_d = 1'b1;
        end
      PRESSED:
        if (row == 4'd0) begin
          state_d = RELEASE;
          cnt_d = '0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (cnt_q == RP_LAST) begin
            cnt_d = '0;
            key_valid_d = !key_valid_q;
          end
`else
          cnt_d = '0;
`endif
        end
      RELEASE:
        if (row != 4'd0) begin
          state_d = PRESSED;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = SCAN;
          col_d = col_q + 2'd1;
          cnt_d = '0;
          key_held_d = 1'b0;
        end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      col_q <= '0;
      cnt_q <= '0;
      row_q <= '0;
      key_value_q <= '0;
      key_valid_q <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      key_value_q <= key_value_d;
      key_valid_q <= key_valid_d;
      key_held_q <= key_held_d;
    end
  end
  assign col_drive = 4'b0001 << col_q;
  assign key_value = key_value_q;
  assign key_valid = key_valid_q;
  assign key_held = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random checks of keypad_scanner (BASE 10 and 16) against a behavioural model
module tb_keypad_scanner;
  localparam int SC = 2, DB = 4, RP = 10;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] row = 4'd0;
  logic [3:0] cd0, cd1, kv0, kv1;
  logic vl0, vl1, hd0, hd1;
  keypad_scanner #(.BASE(10), .SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) u0 (
    .clk(clk), .reset(reset), .row(row), .col_drive(cd0), .key_value(kv0), .key_valid(vl0), .key_held(hd0));
  keypad_scanner #(.BASE(16), .SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) u1 (
    .clk(clk), .reset(reset), .row(row), .col_drive(cd1), .key_value(kv1), .key_valid(vl1), .key_held(hd1));
  always #5 clk = ~clk;
  int checks = 0, failures = 0, pulses = 0;
  int ph, col, tk, run, since, lr, p;
  int mv[2];
  bit mvl, mhd;
  int t10[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 15, 0, 14, 13};
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step(input logic [3:0] r, input logic rs);
    int ri;
    mvl = 1'b0;
    if (rs) begin
      ph = 0; col = 0; tk = 0; run = 0; since = 0; lr = 0; mv[0] = 0; mv[1] = 0; mhd = 1'b0;
    end else if (ph == 0) begin
      if ($countones(r) == 1) begin
        lr = int'(r); run = 0; ph = 1;
      end else begin
        tk++;
        if (tk == SC) begin tk = 0; col = (col + 1) % 4; end
      end
    end else if (ph == 1) begin
      if (int'(r) != lr) begin
        ph = 0; col = (col + 1) % 4; tk = 0;
      end else begin
        run++;
        if (run == DB) begin
          ri = $clog2(lr);
          mv[0] = t10[4 * ri + col];
          mv[1] = 4 * ri + col;
          mvl = 1'b1; mhd = 1'b1; ph = 2; since = 0;
        end
      end
    end else if (ph == 2) begin
      if (r == 4'd0) begin
        ph = 3; run = 0;
      end else begin
        since++;
        if (REP_ON && since == RP) begin mvl = 1'b1; since = 0; end
      end
    end else begin
      if (r != 4'd0) begin
        ph = 2; since = 0;
      end else begin
        run++;
        if (run == DB) begin ph = 0; mhd = 1'b0; col = (col + 1) % 4; tk = 0; end
      end
    end
  endtask
  task automatic tick(input logic [3:0] r, input logic rs);
    row = r;
    reset = rs;
    @(posedge clk);
    model_step(r, rs);
    @(negedge clk);
    chk("col_drive_b10", int'(cd0), 1 << col);
    chk("col_drive_b16", int'(cd1), 1 << col);
    chk("key_value_b10", int'(kv0), mv[0]);
    chk("key_value_b16", int'(kv1), mv[1]);
    chk("key_valid_b10", int'(vl0), int'(mvl));
    chk("key_valid_b16", int'(vl1), int'(mvl));
    chk("key_held_b10", int'(hd0), int'(mhd));
    chk("key_held_b16", int'(hd1), int'(mhd));
    if (vl0) pulses++;
  endtask
  task automatic wait_col(input logic [3:0] c);
    int n = 0;
    while (cd0 != c && n < 20) begin
      tick(4'd0, 1'b0);
      n++;
    end
    chk("wait_col", int'(cd0), int'(c));
  endtask
  initial begin
    @(negedge clk);
    repeat (3) tick(4'd0, 1'b1);
    chk("reset_col", int'(cd0), 1);
    chk("reset_value", int'(kv0), 0);
    chk("reset_held", int'(hd0), 0);
    tick(4'd0, 1'b0); chk("rot0", int'(cd0), 1);
    tick(4'd0, 1'b0); chk("rot1", int'(cd0), 2);
    tick(4'd0, 1'b0); chk("rot2", int'(cd0), 2);
    tick(4'd0, 1'b0); chk("rot3", int'(cd0), 4);
    wait_col(4'b1000);
    p = pulses;
    repeat (6) tick(4'b0100, 1'b0);
    chk("accept_pulses", pulses - p, 1);
    chk("accept_b10", int'(kv0), 12);
    chk("accept_b16", int'(kv1), 11);
    chk("accept_held", int'(hd0), 1);
    chk("accept_frozen", int'(cd0), 8);
    repeat (4) tick(4'd0, 1'b0);
    chk("release_wait_held", int'(hd0), 1);
    tick(4'd0, 1'b0);
    chk("release_done_held", int'(hd0), 0);
    chk("release_next_col", int'(cd0), 1);
    wait_col(4'b0010);
    p = pulses;
    tick(4'b0001, 1'b0); tick(4'b0001, 1'b0); tick(4'd0, 1'b0);
    chk("short_press_pulses", pulses - p, 0);
    chk("short_press_col", int'(cd0), 4);
    wait_col(4'b0001);
    p = pulses;
    repeat (5) tick(4'b1000, 1'b0);
    chk("r3c0_b16", int'(kv1), 12);
    chk("r3c0_b10", int'(kv0), 15);
    tick(4'd0, 1'b0); tick(4'd0, 1'b0); tick(4'b1000, 1'b0);
    chk("bounce_pulses", pulses - p, 1);
    chk("bounce_held", int'(hd1), 1);
    repeat (4) tick(4'd0, 1'b0);
    chk("bounce_release_wait", int'(hd1), 1);
    tick(4'd0, 1'b0);
    chk("bounce_release_done", int'(hd1), 0);
    p = pulses;
    repeat (10) tick(4'b0011, 1'b0);
    chk("multi_bit_pulses", pulses - p, 0);
    repeat (2) tick(4'b0010, 1'b0);
    tick(4'b0010, 1'b1);
    chk("mid_reset_col", int'(cd0), 1);
    chk("mid_reset_value", int'(kv0), 0);
    chk("mid_reset_valid", int'(vl0), 0);
    chk("mid_reset_held", int'(hd0), 0);
    wait_col(4'b0001);
    p = pulses;
    repeat (5) tick(4'b0001, 1'b0);
    chk("hold_b10", int'(kv0), 1);
    repeat (35) tick(4'b0001, 1'b0);
    chk("repeat_pulses", pulses - p, REP_ON ? 4 : 1);
    repeat (6) tick(4'd0, 1'b0);
    for (int k = 0; k < 350; k++) begin
      int sel, len;
      logic [3:0] r;
      sel = $urandom_range(0, 9);
      r = sel < 4 ? 4'd0 : sel < 8 ? 4'b0001 << $urandom_range(0, 3) : 4'($urandom_range(0, 15));
      len = $urandom_range(0, 9) == 0 ? $urandom_range(10, 30) : $urandom_range(1, 12);
      for (int j = 0; j < len; j++) tick(r, $urandom_range(0, 299) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
